dmem_port_arbiter: RTL

- Single-port arbiter and sequencer in front of the 64-word data memory.
- Shares the memory between two requesters:
  - the pipeline MEM stage (CPU port);
  - an external loader/debug port with a req/ack handshake (EXT port).
- Drives the memory's Address, Write_data, MemWrite and MemRead inputs, and inserts wait states to model slower memory.
- Stalls the pipeline until each CPU access completes.

---
 rtl/dmem_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and wait-state sequencer that shares the data memory between the MEM stage
// (CPU port) and an external loader port. Optional address range/alignment check: DMEM_ARB_RANGE_CHECK_EN.
module dmem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_EXT  = 1'b1;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || DEPTH_WORDS < 1) begin : g_param_check
        $error("dmem_port_arbiter: WAIT_CYCLES must be 1..15 and DEPTH_WORDS positive");
    end

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;
    logic        last_grant_r;
    logic        cmd_we_r;
    logic        cmd_err_r;
    logic [31:0] cmd_addr_r;
    logic [31:0] cmd_wdata_r;
    logic [3:0]  cnt_r;
    logic        grant_s;
    logic        grant_owner_s;
    logic [31:0] grant_addr_s;
    logic        bad_addr_s;
    logic        busy_s;
    logic        done_s;

    // Arbitration: a lone requester wins, contention goes to the port that did not win last time.
    always_comb begin
        grant_s       = 1'b0;
        grant_owner_s = OWN_CPU;
        if (cpu_req && ext_req) begin
            grant_s       = 1'b1;
            grant_owner_s = ~last_grant_r;
        end else if (cpu_req) begin
            grant_s       = 1'b1;
            grant_owner_s = OWN_CPU;
        end else if (ext_req) begin
            grant_s       = 1'b1;
            grant_owner_s = OWN_EXT;
        end else begin
            grant_s       = 1'b0;
            grant_owner_s = OWN_CPU;
        end
    end

    assign grant_addr_s = (grant_owner_s == OWN_EXT) ? ext_addr : cpu_addr;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS * 4);
    assign bad_addr_s = (grant_addr_s[1:0] != 2'b00) || (grant_addr_s >= DEPTH_LIMIT);
`else
    assign bad_addr_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a rejected command goes straight to DONE without touching the memory.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = bad_addr_s ? DONE : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Command latch, wait counter and per-owner read data capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner_r      <= OWN_CPU;
            last_grant_r <= OWN_EXT;
            cmd_we_r     <= 1'b0;
            cmd_err_r    <= 1'b0;
            cmd_addr_r   <= 32'd0;
            cmd_wdata_r  <= 32'd0;
            cnt_r        <= 4'd0;
            cpu_rdata    <= 32'd0;
            ext_rdata    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_r      <= grant_owner_s;
                        last_grant_r <= grant_owner_s;
                        cmd_we_r     <= (grant_owner_s == OWN_EXT) ? ext_we : cpu_we;
                        cmd_addr_r   <= grant_addr_s;
                        cmd_wdata_r  <= (grant_owner_s == OWN_EXT) ? ext_wdata : cpu_wdata;
                        cmd_err_r    <= bad_addr_s;
                        cnt_r        <= CNT_LOAD;
                        if (bad_addr_s) begin
                            if (grant_owner_s == OWN_EXT) begin
                                ext_rdata <= 32'd0;
                            end else begin
                                cpu_rdata <= 32'd0;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (!cmd_we_r) begin
                        if (owner_r == OWN_EXT) begin
                            ext_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs decode straight from registers so an asynchronous reset clears them at once.
    assign busy_s    = (state_r == BUSY);
    assign done_s    = (state_r == DONE);
    assign mem_addr  = busy_s ? cmd_addr_r : 32'd0;
    assign mem_wdata = busy_s ? cmd_wdata_r : 32'd0;
    assign mem_write = busy_s & cmd_we_r;
    assign mem_read  = busy_s & ~cmd_we_r;
    assign ext_ack   = done_s & (owner_r == OWN_EXT);
    assign err       = done_s & cmd_err_r;
    assign cpu_stall = cpu_req & ~(done_s & (owner_r == OWN_CPU));

endmodule
